z80_page_mapper: RTL
====================

# z80_page_mapper

Memory-management stage between the Z80 core and `z80_bus_controller`. It holds four 8-bit page-block registers that the CPU writes over I/O ports. It translates each 16-bit CPU address (2-bit page select plus 14-bit offset) into the 22-bit physical bus address. It also stretches accesses to slow page blocks by driving the CPU wait line for a programmable number of `mclk` cycles.

## Interface
Parameters:
- `IO_BASE`, default 8'h70: base I/O port. Ports BASE+0..BASE+3 are page registers 0..3; BASE+4 is the control register.
- `SLOW_MASK`, default 8'h80: a block is slow when `(block & SLOW_MASK) != 0`.
- `WAIT_CYCLES`, default 4: `mclk` cycles of `o_wait_n` low per slow access. 0 disables wait insertion.

Ports:
- `mclk` in 1: master clock. All CPU strobes are synchronous to it.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_addr` in 16: CPU address bus.
- `i_data` in 8: CPU data bus, write direction.
- `i_mreq_n`, `i_iorq_n`, `i_rd_n`, `i_wr_n`, `i_m1_n`, `i_rfsh_n` in 1 each: CPU control strobes.
- `o_data` out 8: read-back data.
- `o_data_oe` out 1: drive `o_data` onto the CPU data bus.
- `o_block` out 8: selected page block.
- `o_phys_addr` out 22: `{o_block, i_addr[13:0]}`.
- `o_wait_n` out 1: to CPU nWAIT.

## Operation
- **Registers:**
  - `page[0..3]` reset to 8'h00, 8'h01, 8'h02, 8'h03.
  - `ctrl` resets to 8'h00. Bit0 = map enable; bits 7:1 read as 0.
- **Translation (combinational):**
  - Map enable = 1: `o_block = page[i_addr[15:14]]`.
  - Map enable = 0: `o_block = {6'b0, i_addr[15:14]}`.
- **I/O decode:**
  - Hit = `!i_iorq_n && i_m1_n && i_addr[7:0] in [IO_BASE, IO_BASE+4]`.
  - Interrupt acknowledge (IORQ and M1 both low) is never a hit.
- **Write:**
  - Hit with `!i_wr_n` is sampled into a registered strobe.
  - The register is written on the first `mclk` edge where the registered strobe is 1 and its previous value was 0.
  - Exactly one write per I/O cycle, however long the cycle is stretched.
- **Read:**
  - Hit with `!i_rd_n` asserts `o_data_oe` combinationally.
  - `o_data` carries the addressed register. `o_data` = 8'h00 when `o_data_oe` = 0.
- **Wait FSM states:**
  - IDLE:
    - Registered `i_mreq_n` falls, `i_rfsh_n` = 1, `WAIT_CYCLES` != 0, and current `o_block` is slow: load counter = `WAIT_CYCLES`, go to STRETCH.
    - Otherwise stay in IDLE.
  - STRETCH:
    - `o_wait_n` = 0; counter decrements each `mclk`.
    - Counter reaches 0: go to DONE.
  - DONE:
    - `o_wait_n` = 1; hold until `i_mreq_n` = 1, then go to IDLE.
    - This guarantees one stretch per access.
  - `i_mreq_n` rising in any state forces IDLE, counter 0 and `o_wait_n` = 1 on the next edge.
- **Exclusions:**
  - Refresh cycles (`i_rfsh_n` = 0) never insert waits.
  - I/O cycles never insert waits.

## Timing
- **Reset values:**
  - `o_wait_n` = 1, `o_data_oe` = 0, `o_data` = 0.
  - `o_block` = `{6'b0, i_addr[15:14]}`.
- **Translation latency:** 0 cycles from `i_addr`. A register write is visible on `o_phys_addr` the cycle after the commit edge.
- **Write latency:** commit on the 2nd `mclk` edge after the `i_wr_n` and `i_iorq_n` low condition first holds (1 sample stage plus edge detect).
- **Wait latency:**
  - `o_wait_n` falls 1 `mclk` after the `mreq_n` low sample.
  - It stays low for exactly `WAIT_CYCLES` cycles.
- **Slow-block evaluation:** slowness is evaluated from the `o_block` value at the sampling edge. A page-register write during a stretch does not change the running count.
- **Async reset mid-operation:**
  - Stretch: `o_wait_n` returns to 1 immediately.
  - Page registers: return to identity values.
  - Pending writes: dropped.

## Test plan
- **Reset and identity map:** after reset, map disabled, `i_addr`=16'hC123 -> `o_phys_addr`=22'h00C123, `o_wait_n`=1.
- **Page write and translation:**
  - Stimulus: OUT (0x72),8'h5A; OUT (0x74),8'h01; then `i_addr`=16'h8ABC.
  - Expected: `o_phys_addr`=22'h168ABC.
  - Holding the I/O write 10 cycles writes once.
- **Read-back:** IN from 0x72 -> `o_data_oe`=1, `o_data`=8'h5A. IN from 0x74 -> 8'h01. IN from 0x75 -> `o_data_oe`=0.
- **Slow access:**
  - Stimulus: `page[1]`=8'h80; memory read at 16'h4000.
  - Expected: `o_wait_n` low exactly 4 cycles, starting 1 cycle after `mreq_n` sample.
  - A refresh cycle to the same block: no wait.
- **Aborted stretch:** `i_mreq_n` released after 2 wait cycles -> `o_wait_n`=1 next edge. The following slow access gets a full 4 cycles.
- **Interrupt acknowledge and reset:**
  - `i_m1_n`=0, `i_iorq_n`=0, `i_addr[7:0]`=8'h70: no write, `o_data_oe`=0.
  - `reset_n` pulse mid-stretch: `o_wait_n`=1 immediately, `page[0]`=8'h00.

Source files
------------

// File: rtl/z80_page_mapper.sv
// z80_page_mapper
// Memory-management stage between the Z80 core and the bus controller.
// Four page-block registers and a control register are written over I/O
// ports IO_BASE+0..IO_BASE+4. Each CPU address is translated combinationally
// into a 22-bit physical address. Accesses to slow blocks are stretched by
// holding o_wait_n low for WAIT_CYCLES mclk cycles.
//
// Ports:
//   mclk, reset_n         master clock, asynchronous active-low reset
//   i_addr[15:0]          CPU address (page select in [15:14])
//   i_data[7:0]           CPU write data
//   i_mreq_n .. i_rfsh_n  CPU control strobes, synchronous to mclk
//   o_data[7:0]           register read-back (0 when not driven)
//   o_data_oe             drive o_data onto the CPU data bus
//   o_block[7:0]          selected page block
//   o_phys_addr[21:0]     {o_block, i_addr[13:0]}
//   o_wait_n              CPU nWAIT
module z80_page_mapper #(
  parameter logic [7:0] IO_BASE     = 8'h70,
  parameter logic [7:0] SLOW_MASK   = 8'h80,
  parameter int         WAIT_CYCLES = 4
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_mreq_n,
  input  logic        i_iorq_n,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic        i_m1_n,
  input  logic        i_rfsh_n,
  output logic [7:0]  o_data,
  output logic        o_data_oe,
  output logic [7:0]  o_block,
  output logic [21:0] o_phys_addr,
  output logic        o_wait_n
);

  localparam logic [7:0] LP_WAIT    = 8'(WAIT_CYCLES);
  localparam bit         LP_WAIT_EN = (WAIT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  logic [7:0] r_page [4];
  logic       r_map_en;

  // write path: registered strobe plus its delayed copy for edge detect
  logic       r_wr_smp;
  logic       r_wr_smp_d;
  logic [2:0] r_wr_sel;
  logic [7:0] r_wr_data;

  // wait path
  logic       r_mreq_n_s;
  logic       r_mreq_n_d;
  logic       r_rfsh_n_s;
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;

  logic       w_in_range;
  logic       w_io_hit;
  logic [2:0] w_io_sel;
  logic       w_wr_hit;
  logic       w_commit;
  logic       w_slow;
  logic       w_mreq_fall;

  // Range check done in 9 bits so IO_BASE+4 cannot wrap past 8'hFF.
  assign w_in_range = ({1'b0, i_addr[7:0]} >= {1'b0, IO_BASE}) &&
                      ({1'b0, i_addr[7:0]} <= ({1'b0, IO_BASE} + 9'd4));
  // Interrupt acknowledge (IORQ with M1 low) is never a register access.
  assign w_io_hit   = !i_iorq_n && i_m1_n && w_in_range;
  // Low three bits of the difference equal the low bits of the full offset.
  assign w_io_sel   = 3'(i_addr[2:0] - IO_BASE[2:0]);
  assign w_wr_hit   = w_io_hit && !i_wr_n;
  // Commit only on the rising edge of the registered strobe, so a stretched
  // I/O cycle still produces exactly one write.
  assign w_commit   = r_wr_smp && !r_wr_smp_d;

  // Translation
  assign o_block     = r_map_en ? r_page[i_addr[15:14]] : {6'b0, i_addr[15:14]};
  assign o_phys_addr = {o_block, i_addr[13:0]};
  assign w_slow      = (o_block & SLOW_MASK) != 8'h00;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_smp   <= 1'b0;
      r_wr_smp_d <= 1'b0;
      r_wr_sel   <= 3'd0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_smp   <= w_wr_hit;
      r_wr_smp_d <= r_wr_smp;
      // capture target and data on the first sample of the cycle
      if (w_wr_hit && !r_wr_smp) begin
        r_wr_sel  <= w_io_sel;
        r_wr_data <= i_data;
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        r_page[i] <= 8'(i);
      end
      r_map_en <= 1'b0;
    end else if (w_commit) begin
      if (r_wr_sel[2]) begin
        r_map_en <= r_wr_data[0];
      end else begin
        r_page[r_wr_sel[1:0]] <= r_wr_data;
      end
    end
  end

  // Read-back
  always_comb begin
    o_data_oe = w_io_hit && !i_rd_n;
    o_data    = 8'h00;
    if (o_data_oe) begin
      case (w_io_sel)
        3'd0:    o_data = r_page[0];
        3'd1:    o_data = r_page[1];
        3'd2:    o_data = r_page[2];
        3'd3:    o_data = r_page[3];
        3'd4:    o_data = {7'b0, r_map_en};
        default: o_data = 8'h00;
      endcase
    end
  end

  // Wait FSM: state register
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_mreq_n_s <= 1'b1;
      r_mreq_n_d <= 1'b1;
      r_rfsh_n_s <= 1'b1;
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
    end else begin
      r_mreq_n_s <= i_mreq_n;
      r_mreq_n_d <= r_mreq_n_s;
      r_rfsh_n_s <= i_rfsh_n;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
    end
  end

  // Falling edge of the registered MREQ; the stretch starts one mclk after
  // the sample that first saw MREQ low.
  assign w_mreq_fall = !r_mreq_n_s && r_mreq_n_d;

  // Wait FSM: next state
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (i_mreq_n) begin
      // end of access (or abort) always returns to idle
      w_state_next = ST_IDLE;
      w_cnt_next   = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mreq_fall && r_rfsh_n_s && LP_WAIT_EN && w_slow) begin
            w_state_next = ST_STRETCH;
            w_cnt_next   = LP_WAIT;
          end
        end
        ST_STRETCH: begin
          w_cnt_next = r_cnt - 8'd1;
          if (r_cnt <= 8'd1) begin
            w_state_next = ST_DONE;
            w_cnt_next   = 8'd0;
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 8'd0;
        end
      endcase
    end
  end

  assign o_wait_n = (r_state != ST_STRETCH);

endmodule
